// File: rtl/rr_arbiter8.sv
// rr_arbiter8: registered 8-way round-robin arbiter; each grant is held until it
// is acknowledged or TIMEOUT cycles pass, then the priority pointer moves past the winner.
module rr_arbiter8 #(
  parameter int TIMEOUT = 15,
  parameter int CW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       gnt_ack,
  output logic [0:7] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [2:0] ptr;
  logic [2:0] pick;
  logic [CW-1:0] holdCnt;
  // Scan from the furthest offset down so the offset nearest ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = 7; k >= 0; k--)
      pick = req[ptr + 3'(k)] ? ptr + 3'(k) : pick;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      holdCnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state <= GRANT;
          gnt <= 8'b1000_0000 >> pick;
          gnt_idx <= pick;
          gnt_valid <= 1'b1;
          holdCnt <= '0;
        end
      end else if (gnt_ack || holdCnt == CW'(TIMEOUT - 1)) begin
        state <= IDLE;
        gnt <= '0;
        gnt_idx <= '0;
        gnt_valid <= 1'b0;
        ptr <= gnt_idx + 3'd1;
        timeout <= !gnt_ack;
      end else begin
        holdCnt <= holdCnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Registered 8-way round-robin arbiter that sits directly upstream of encoder8to3.
- Takes 8 request lines and issues a one-hot grant vector, ordered Y0..Y7, that feeds encoder8to3 directly.
- Also issues the matching 3-bit grant index and a valid flag.
- The grant is held until the consumer acknowledges it or a timeout expires; a rotating priority pointer guarantees fairness.

Parameters:
- TIMEOUT, 15, max cycles a grant is held without gnt_ack before forced release (1..255).
- CW, 8, width of the internal hold counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  [7:0]  request lines; req[i] = requester i
- gnt_ack  input  1  consumer accepts current grant; sampled only while gnt_valid=1
- gnt  output  [0:7]  one-hot grant, bit i = requester i (MSB-first indexing, matches encoder8to3 input)
- gnt_idx  output  [2:0]  binary index of granted requester
- gnt_valid  output  1  grant outputs are meaningful
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- All outputs are registered; nothing is combinational from input to output.
- Reset (sync, high) values:
  - gnt=8'b0, gnt_idx=3'd0, gnt_valid=0, timeout=0
  - ptr=3'd0, hold counter=0
  - state=IDLE
  - Reset asserted mid-grant drops the grant on the next edge; no ack or timeout pulse is produced.
- States: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE; outputs zero.
  - Else: select the first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7 mod 8.
  - Next edge: gnt[i]=1 (all other bits 0), gnt_idx=i, gnt_valid=1, counter=0, go to GRANT.
  - Latency is 1 cycle from req sampled to gnt_valid.
- GRANT:
  - Grant is locked. Changes on req, including deassertion of the granted line, are ignored.
  - On gnt_ack=1: next edge clears gnt, gnt_idx and gnt_valid, sets ptr=(gnt_idx+1) mod 8, goes to IDLE.
  - On gnt_ack=0 with counter==TIMEOUT-1: same release, ptr=(gnt_idx+1) mod 8, timeout=1 for exactly that one cycle.
  - On gnt_ack=0 otherwise: counter increments; outputs unchanged.
  - If gnt_ack=1 and the timeout condition fall in the same cycle, ack wins: timeout stays 0.
- Mandatory bubble: at least one IDLE cycle between consecutive grants, so gnt_valid drops for ≥1 cycle after every release.
- Pointer wrap: ptr is 3-bit, so 7+1 wraps to 0.
- gnt_ack while gnt_valid=0 is ignored.
- Invariants, checked every cycle:
  - gnt is always 0 or one-hot.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt_idx equals the encoder8to3 encoding of gnt.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- Fairness:
  - Stimulus: req=8'hFF held; gnt_ack=1 one cycle after each gnt_valid rise.
  - Required: grants issued in order idx 0,1,2,...,7,0 with one idle cycle between each.
  - Required: gnt = 8'b1000_0000 for idx 0 and 8'b0000_0001 for idx 7 (MSB-first [0:7] indexing).
  - Required: encoder8to3 on gnt reproduces gnt_idx.
- Pointer skip/wrap:
  - Stimulus: after granting idx 6 and acking, set req=8'b0010_0001.
  - Required: next grant is idx 0, because the scan runs 7,0.
  - Required: after acking idx 0, the following grant is idx 5.
- Timeout:
  - Stimulus: req=8'h08, never ack, TIMEOUT=15.
  - Required: gnt_idx=3 with gnt_valid=1 for exactly 15 cycles.
  - Required: then timeout=1 for one cycle with gnt_valid=0; a re-grant of idx 3 follows one cycle later.
- Ack/timeout collision and lock:
  - Stimulus: assert gnt_ack on the 15th held cycle.
  - Required: release with timeout=0.
  - Stimulus: drop req[3] mid-grant.
  - Required: grant stays on idx 3 until ack.
- Reset mid-grant:
  - Stimulus: pulse reset for 1 cycle while gnt_idx=4.
  - Required: next cycle all outputs are 0 and ptr=0; with req=8'hFF the next grant is idx 0.
